rd84_pattern_gen: RTL and testbench

- Inverse companion to the rd84 weight-detector benchmarks. rd84 maps an 8-bit vector to its weight; this block maps a requested weight k to the full ordered stream of 8-bit vectors whose popcount equals k.
- Vectors are emitted in ascending numeric order, one per valid/ready handshake.
- Sits in front of the mapped rd84 NOR netlists in the MAGIC evaluation flow. It supplies weight-class stimulus for exhaustive checking and for crossbar write sequences.

---
 rtl/rd84_gen_pkg.sv | 25 ++
 rtl/rd84_pattern_gen_gosper_next.sv | 30 +++
 rtl/rd84_pattern_gen.sv | 98 +++++++++
 tb/tb_rd84_pattern_gen.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rd84_gen_pkg.sv
// Shared constants, state encoding and class-boundary helpers for the rd84 weight-class pattern generator.
package rd84_gen_pkg;

    localparam int W  = 8;
    localparam int KW = 4;
    localparam int IW = 7;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Lowest vector of weight k: k ones packed at the LSB end.
    function automatic logic [W-1:0] first_word(input logic [KW-1:0] k);
        logic [W:0] one_hot;
        one_hot = (W+1)'(1) << k;
        return W'(one_hot - (W+1)'(1));
    endfunction

    // Highest vector of weight k: k ones packed at the MSB end.
    function automatic logic [W-1:0] last_word(input logic [KW-1:0] k);
        return first_word(k) << (KW'(W) - k);
    endfunction

endpackage

// File: rtl/rd84_pattern_gen_gosper_next.sv
// Combinational Gosper step: next larger vector with the same popcount.
module gosper_next
    import rd84_gen_pkg::*;
(
    input  logic [W-1:0] x,
    output logic [W-1:0] nxt
);

    logic [W:0]    x_ext;
    logic [W:0]    c;
    logic [W:0]    r;
    logic [W:0]    tail;
    logic [KW-1:0] ctz;

    assign x_ext = {1'b0, x};
    assign c     = x_ext & (~x_ext + (W+1)'(1));
    assign r     = x_ext + c;
    assign tail  = (r ^ x_ext) >> 2;

    // c is one-hot (or zero), so a priority encode gives its trailing-zero count.
    always_comb begin
        ctz = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (c[i]) ctz = KW'(i);
        end
    end

    assign nxt = W'(r | (tail >> ctz));

endmodule

// File: rtl/rd84_pattern_gen.sv
// Streams every W-bit vector of a requested popcount in ascending order over a valid/ready port.
//
//   state | meaning
//   IDLE  | waiting for start; weight > W raises err
//   EMIT  | out_word valid, advances on each handshake until the last word
module rd84_pattern_gen
    import rd84_gen_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [KW-1:0] weight,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_word,
    output logic [IW-1:0] out_index,
    output logic          done,
    output logic          err
);

    state_t        state, state_nxt;
    logic [KW-1:0] k_q, k_nxt;
    logic [W-1:0]  word_nxt, word_gosper;
    logic [IW-1:0] index_nxt;
    logic          busy_nxt, valid_nxt, done_nxt, err_nxt;

    gosper_next u_gosper_next (
        .x   (out_word),
        .nxt (word_gosper)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            k_q       <= '0;
            out_word  <= '0;
            out_index <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            k_q       <= k_nxt;
            out_word  <= word_nxt;
            out_index <= index_nxt;
            busy      <= busy_nxt;
            out_valid <= valid_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        k_nxt     = k_q;
        word_nxt  = out_word;
        index_nxt = out_index;
        busy_nxt  = busy;
        valid_nxt = out_valid;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (weight > KW'(W)) begin
                        err_nxt = 1'b1;
                    end else begin
                        k_nxt     = weight;
                        word_nxt  = first_word(weight);
                        index_nxt = '0;
                        busy_nxt  = 1'b1;
                        valid_nxt = 1'b1;
                        state_nxt = EMIT;
                    end
                end
            end
            EMIT: begin
                if (out_valid && out_ready) begin
                    // The last word of a class has no successor; word and index hold.
                    if (out_word == last_word(k_q)) begin
                        busy_nxt  = 1'b0;
                        valid_nxt = 1'b0;
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        word_nxt  = word_gosper;
                        index_nxt = out_index + IW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rd84_pattern_gen.sv
// Scoreboard bench: expected class streams are built by brute-force popcount enumeration.
module tb_rd84_pattern_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] weight;
    logic       busy;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_word;
    logic [6:0] out_index;
    logic       done;
    logic       err;

    rd84_pattern_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .weight    (weight),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_index (out_index),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] word;
        logic [6:0] idx;
        int         k;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   hs_count = 0;
    bit   seen[256];
    bit   prev_stall = 0;
    logic [7:0] stall_word;
    logic [6:0] stall_idx;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Consumer-side monitor: handshakes are judged at the negedge before the accepting posedge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall && out_valid) begin
                chk("stall_word", 32'(out_word), 32'(stall_word));
                chk("stall_idx", 32'(out_index), 32'(stall_idx));
            end
            prev_stall = out_valid && !out_ready;
            stall_word = out_word;
            stall_idx  = out_index;
            if (out_valid && out_ready) begin
                hs_count++;
                seen[out_word] = 1'b1;
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("word", 32'(out_word), 32'(e.word));
                    chk("index", 32'(out_index), 32'(e.idx));
                    chk("rd84_weight", $countones(out_word), e.k);
                end
            end
        end else begin
            prev_stall = 0;
        end
    end

    task automatic push_class(input int k);
        int idx = 0;
        for (int v = 0; v < 256; v++) begin
            if ($countones(v) == k) begin
                exp_t e;
                e.word = 8'(v);
                e.idx  = 7'(idx);
                e.k    = k;
                sb.push_back(e);
                idx++;
            end
        end
    endtask

    // Called just after a posedge; returns just after the posedge that samples start.
    task automatic start_class(input int k);
        start  = 1'b1;
        weight = 4'(k);
        if (k <= 8) push_class(k);
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 2000) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    localparam int CLASS_SIZE [9] = '{1, 8, 28, 56, 70, 56, 28, 8, 1};

    initial begin
        int cyc;
        int base;
        int n_seen;
        rst_n     = 1'b0;
        start     = 1'b0;
        weight    = '0;
        out_ready = 1'b1;
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_word", 32'(out_word), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // weight 2, ready tied high: first valid one cycle after start, done at cycle 29
        start_class(2);
        chk("w2_first_valid", 32'(out_valid), 32'd1);
        chk("w2_first_word", 32'(out_word), 32'h03);
        chk("w2_busy", 32'(busy), 32'd1);
        wait_done(cyc);
        chk("w2_done_cycle", 32'(1 + cyc), 32'd29);
        chk("w2_done_valid", 32'(out_valid), 32'd0);
        chk("w2_done_busy", 32'(busy), 32'd0);
        chk("w2_last_word", 32'(out_word), 32'hC0);
        @(posedge clk); #1;
        chk("w2_done_pulse", 32'(done), 32'd0);

        // sweep 0..8, each class started in the done cycle of the previous one
        for (int v = 0; v < 256; v++) seen[v] = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            base = hs_count;
            start_class(k);
            wait_done(cyc);
            chk($sformatf("class_size_k%0d", k), 32'(hs_count - base), 32'(CLASS_SIZE[k]));
        end
        n_seen = 0;
        for (int v = 0; v < 256; v++) if (seen[v]) n_seen++;
        chk("sweep_distinct", 32'(n_seen), 32'd256);
        @(posedge clk); #1;

        // weight 4 with random backpressure
        base = hs_count;
        start_class(4);
        cyc = 0;
        while (!done && cyc < 2000) begin
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            cyc++;
        end
        if (!done) chk("w4_timeout", 32'd0, 32'd1);
        out_ready = 1'b1;
        chk("w4_handshakes", 32'(hs_count - base), 32'd70);
        chk("w4_final_word", 32'(out_word), 32'hF0);
        chk("w4_final_idx", 32'(out_index), 32'd69);
        @(posedge clk); #1;

        // illegal weight, then a single-word class
        start  = 1'b1;
        weight = 4'd9;
        @(posedge clk); #1;
        start  = 1'b0;
        chk("w9_err", 32'(err), 32'd1);
        chk("w9_busy", 32'(busy), 32'd0);
        chk("w9_valid", 32'(out_valid), 32'd0);
        chk("w9_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        chk("w9_err_pulse", 32'(err), 32'd0);
        base = hs_count;
        start_class(8);
        chk("w8_word", 32'(out_word), 32'hFF);
        wait_done(cyc);
        chk("w8_handshakes", 32'(hs_count - base), 32'd1);
        @(posedge clk); #1;

        // asynchronous reset after the 10th handshake of weight 3
        base = hs_count;
        start_class(3);
        cyc = 0;
        while (hs_count < base + 10 && cyc < 200) begin
            @(negedge clk); #1;
            cyc++;
        end
        if (hs_count < base + 10) chk("w3_hs_timeout", 32'd0, 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_word", 32'(out_word), 32'd0);
        chk("arst_index", 32'(out_index), 32'd0);
        chk("arst_done_err", 32'({done, err}), 32'd0);
        sb.delete();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", 32'(out_valid), 32'd0);
        start_class(3);
        chk("w3_restart_word", 32'(out_word), 32'h07);
        chk("w3_restart_idx", 32'(out_index), 32'd0);
        wait_done(cyc);
        @(posedge clk); #1;

        // start while busy must be ignored
        base = hs_count;
        start_class(1);
        @(posedge clk); #1;
        start  = 1'b1;
        weight = 4'd5;
        @(posedge clk); #1;
        start  = 1'b0;
        chk("busy_start_no_err", 32'(err), 32'd0);
        wait_done(cyc);
        chk("w1_handshakes", 32'(hs_count - base), 32'd8);
        chk("w1_last_word", 32'(out_word), 32'h80);
        @(posedge clk); #1;
        chk("idle_after_w1", 32'(out_valid), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
